// File: rtl/tape_loader_pkg.sv
// Shared types and default parameter values for the tape loader.
package tape_loader_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    SEALED = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_W       = 6;
  localparam int unsigned DEF_DEPTH        = 64;
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_DEBOUNCE_CYC = 4;

endpackage

// File: rtl/tape_loader_input_conditioner.sv
// One-bit input conditioner: synchronizer chain, optional debounce, rising-edge pulse.
// Debounce is present only when TAPE_LOADER_DEBOUNCE_EN is defined.
module input_conditioner #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level;
  logic                   level_prev;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef TAPE_LOADER_DEBOUNCE_EN
  // Counter wide enough to hold DEBOUNCE_CYC-1.
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);

  logic [DW-1:0] deb_cnt;
  logic          deb_level;

  // Accept a new level only after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
    end else if (sync != deb_level) begin
      if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
        deb_level <= sync;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign level = deb_level;
`else
  assign level = sync;
`endif

  // Remember the previous accepted level for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
    end
  end

  assign pulse = level & ~level_prev;

endmodule

// File: rtl/tape_loader.sv
// Tape loader: buttons store synchronized switch symbols into a buffer, a "done"
// press seals the tape, and the consumer drains it in order.
// Optional debounce of the buttons is enabled by defining TAPE_LOADER_DEBOUNCE_EN.
module tape_loader
  import tape_loader_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      data_async,
  input  logic                   next_async,
  input  logic                   done_async,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   sealed,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] data_sync_q [SYNC_STAGES];
  logic [DATA_W-1:0] data_sync;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  state_t            state;
  logic              next_pulse;
  logic              done_pulse;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              seal_req;

  input_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_next_cond (
    .clock(clock),
    .reset(reset),
    .din  (next_async),
    .pulse(next_pulse)
  );

  input_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_done_cond (
    .clock(clock),
    .reset(reset),
    .din  (done_async),
    .pulse(done_pulse)
  );

  // Synchronize the symbol switches; they are never debounced.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      data_sync_q[0] <= data_async;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign data_sync = data_sync_q[SYNC_STAGES-1];

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_en    = (state == LOAD) && next_pulse && !full;
  // A simultaneous store counts toward the non-empty condition for sealing.
  assign seal_req = (state == LOAD) && done_pulse && (!empty || next_pulse);

  // Buffer storage; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= data_sync;
  end

  // Load/seal FSM with count, pointers and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= LOAD;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (next_pulse) begin
            if (!full) begin
              count  <= count + CW'(1);
              wr_ptr <= wr_ptr + AW'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
          if (seal_req) state <= SEALED;
        end
        SEALED: begin
          if (rd_ready && !empty) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - CW'(1);
            if (count == CW'(1)) begin
              state    <= LOAD;
              overflow <= 1'b0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign sealed   = (state == SEALED);
  assign rd_valid = sealed && !empty;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule
